nvmem_write_scheduler: RTL and testbench
========================================

Name: nvmem_write_scheduler

Overview:
- Sits between the CPU data port, the DMA write port and the non-volatile memory (NVMEM) write port.
- Arbitrates NVMEM writes round-robin between the two requesters.
- Buffers accepted writes in a small FIFO.
- Issues writes to NVMEM under a token-bucket rate limit, with a req/ack handshake and an ack timeout.
- Replaces hard-reset rate limiting with back-pressure: excess writes stall rather than reset the device.

Parameters:
NVMEM_START, 'hE000, lowest NVMEM address; writes below it are rejected
DEPTH, 4, FIFO entries (power of 2, >=2)
BUCKET_MAX, 4, token bucket capacity (max burst of NVMEM writes)
REFILL_PERIOD, 200, clock ticks per token refill
ACK_TIMEOUT, 16, cycles in REQ without nv_ack before abort

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cpu_addr  in  16  CPU write address
cpu_din  in  16  CPU write data
cpu_wen  in  1  CPU write valid
cpu_ready  out  1  CPU write accepted this cycle when cpu_wen=1
dma_addr  in  16  DMA write address
dma_din  in  16  DMA write data
dma_wen  in  1  DMA write valid
dma_ready  out  1  DMA write accepted this cycle when dma_wen=1
nv_addr  out  16  NVMEM write address (FIFO head)
nv_dout  out  16  NVMEM write data (FIFO head)
nv_req  out  1  NVMEM write request
nv_ack  in  1  NVMEM write complete
addr_err  out  1  one-cycle pulse: accepted write had addr < NVMEM_START, discarded
nv_err  out  1  one-cycle pulse: ack timeout, head entry dropped
throttled  out  1  FIFO non-empty and tokens==0
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - cpu_ready=0, dma_ready=0, nv_req=0, addr_err=0, nv_err=0, throttled=0, fifo_level=0, nv_addr=0, nv_dout=0.
  - tokens=BUCKET_MAX, refill counter=0, RR pointer=CPU, FSM=IDLE.
- Reset mid-transaction: nv_req drops immediately (asynchronous); FIFO contents are lost.
- Arbitration (combinational ready):
  - full = (fifo_level==DEPTH), registered.
  - Only one requester wins per cycle.
  - If only one requester is valid and !full, its ready=1.
  - If both are valid and !full, the RR pointer picks the winner and the pointer flips to the other requester after that contested grant.
  - If full, both readys=0. A same-cycle pop does not free a slot for a push in that cycle.
  - A push occurs on (wen && ready) at the rising edge.
- Address filter:
  - An accepted write with addr < NVMEM_START is not pushed.
  - addr_err=1 for the cycle after acceptance.
- FIFO:
  - DEPTH entries of {addr[15:0], data[15:0]}, with wrapping read and write pointers.
  - Simultaneous push and pop: level is unchanged.
  - nv_addr/nv_dout are driven registered from the head entry when entering REQ, and are held stable throughout REQ.
- Token bucket:
  - The refill counter counts 0..REFILL_PERIOD-1. On wrap, tokens = min(tokens+1, BUCKET_MAX).
  - Consume 1 token on the IDLE->REQ transition.
  - Same-cycle refill and consume: net 0; saturation is applied after the net change.
  - tokens width is clog2(BUCKET_MAX+1) and never underflows.
- Issue FSM:
  - IDLE: if fifo_level>0 and tokens>0, go to REQ at the next edge, load the head onto nv_addr/nv_dout, and set nv_req=1. Otherwise stay in IDLE.
  - REQ: nv_req=1, timeout counter increments each cycle.
    - If nv_ack: pop the head, nv_req=0, go to IDLE.
    - Else if timeout counter reaches ACK_TIMEOUT-1: pop the head, nv_err pulse, nv_req=0, go to IDLE.
    - The ack check has priority over the timeout check in the same cycle.
  - There is always at least 1 IDLE cycle between requests, so there are no back-to-back nv_req pulses.
  - An nv_ack seen in IDLE is ignored.
- Latency: a write pushed at edge k raises nv_req after edge k+1 (FIFO empty, FSM IDLE, tokens>0).
- throttled = (fifo_level>0) && (tokens==0), registered.

Test Plan:
- Single CPU write addr='hE010, data='h1234, nv_ack 2 cycles after nv_req -> nv_req high after push edge +1, nv_addr='hE010, nv_dout='h1234, tokens 4->3, fifo_level 1->0 on ack.
- CPU and DMA both valid for 4 cycles, nv_ack held 0 -> grants alternate CPU, DMA, CPU, DMA; fifo_level reaches 4; both readys=0 while full.
- 6 back-to-back writes with immediate nv_ack -> first 4 issue, then throttled=1. The 5th issues only after the refill wrap (cycle 200 since reset); the 6th issues 200 cycles after the 5th.
- Write addr='hD000 -> accepted, addr_err pulses once, fifo_level stays 0, no nv_req.
- nv_ack never asserted -> nv_req high for exactly 16 cycles, nv_err pulses once, entry dropped, FSM back in IDLE.
- Assert reset while nv_req=1 with 3 entries queued -> nv_req=0 immediately, fifo_level=0, tokens=4 after release.

Source files
------------

// File: rtl/nvmem_write_scheduler.sv
// NVMEM write scheduler: round-robin CPU/DMA arbitration into a small FIFO,
// token-bucket rate limited issue to NVMEM with req/ack and ack timeout.
// Excess writes back-pressure the requesters instead of resetting the device.
module nvmem_write_scheduler #(
  parameter logic [15:0] NVMEM_START   = 16'hE000,
  parameter int          DEPTH         = 4,
  parameter int          BUCKET_MAX    = 4,
  parameter int          REFILL_PERIOD = 200,
  parameter int          ACK_TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              cpu_addr,
  input  logic [15:0]              cpu_din,
  input  logic                     cpu_wen,
  output logic                     cpu_ready,
  input  logic [15:0]              dma_addr,
  input  logic [15:0]              dma_din,
  input  logic                     dma_wen,
  output logic                     dma_ready,
  output logic [15:0]              nv_addr,
  output logic [15:0]              nv_dout,
  output logic                     nv_req,
  input  logic                     nv_ack,
  output logic                     addr_err,
  output logic                     nv_err,
  output logic                     throttled,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(BUCKET_MAX + 1);
  localparam int CW = $clog2(REFILL_PERIOD + 1);
  localparam int OW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;          // 0: CPU wins next contest, 1: DMA
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [TW-1:0]   tokens_q, tokens_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   to_q, to_d;
  logic [15:0]     nva_q, nvd_q;
  logic            addr_err_q, nv_err_q, thr_q;
  logic [31:0]     mem_q [DEPTH];

  logic            full, acc, push, bad, pop, consume, load, tmo, wrap;
  logic [15:0]     wr_addr, wr_data;
  logic [TW:0]     tsum;

  // Arbitration: a full FIFO stalls both sides; contests resolved by rr_q.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    cpu_ready = cpu_wen && !full && (!dma_wen || !rr_q);
    dma_ready = dma_wen && !full && (!cpu_wen || rr_q);
    acc       = cpu_ready || dma_ready;
    wr_addr   = cpu_ready ? cpu_addr : dma_addr;
    wr_data   = cpu_ready ? cpu_din  : dma_din;
    push      = acc && (wr_addr >= NVMEM_START);
    bad       = acc && (wr_addr <  NVMEM_START);
    rr_d      = (cpu_wen && dma_wen && !full) ? ~rr_q : rr_q;
  end

  // Issue FSM next state; one IDLE cycle always separates requests.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    pop     = 1'b0;
    tmo     = 1'b0;
    consume = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0 && tokens_q != '0) begin
          state_d = REQ;
          consume = 1'b1;
          load    = 1'b1;
          to_d    = '0;
        end
      end
      REQ: begin
        to_d = to_q + 1'b1;
        if (nv_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (to_q == OW'(ACK_TIMEOUT - 1)) begin
          pop     = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy, token bucket (saturate after net refill/consume) and refill timer.
  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
    wrap    = (cnt_q == CW'(REFILL_PERIOD - 1));
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    tsum    = {1'b0, tokens_q} + (TW+1)'(wrap) - (TW+1)'(consume);
    tokens_d = (tsum > (TW+1)'(BUCKET_MAX)) ? TW'(BUCKET_MAX) : tsum[TW-1:0];
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tokens_q   <= TW'(BUCKET_MAX);
      cnt_q      <= '0;
      to_q       <= '0;
      nva_q      <= '0;
      nvd_q      <= '0;
      addr_err_q <= 1'b0;
      nv_err_q   <= 1'b0;
      thr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      level_q    <= level_d;
      tokens_q   <= tokens_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      addr_err_q <= bad;
      nv_err_q   <= tmo;
      thr_q      <= (level_d != '0) && (tokens_d == '0);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (load) {nva_q, nvd_q} <= mem_q[rptr_q];
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {wr_addr, wr_data};
  end

  assign nv_req     = (state_q == REQ);
  assign nv_addr    = nva_q;
  assign nv_dout    = nvd_q;
  assign addr_err   = addr_err_q;
  assign nv_err     = nv_err_q;
  assign throttled  = thr_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_nvmem_write_scheduler.sv
// Self-checking bench for nvmem_write_scheduler: scoreboard of accepted
// writes compared against the entries the DUT issues on the NVMEM port.
module tb_nvmem_write_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0, cpu_din = '0, dma_addr = '0, dma_din = '0;
  logic        cpu_wen = 1'b0, dma_wen = 1'b0, nv_ack = 1'b0;
  logic        cpu_ready, dma_ready, nv_req, addr_err, nv_err, throttled;
  logic [15:0] nv_addr, nv_dout;
  logic [2:0]  fifo_level;

  nvmem_write_scheduler dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wen(cpu_wen), .cpu_ready(cpu_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_wen(dma_wen), .dma_ready(dma_ready),
    .nv_addr(nv_addr), .nv_dout(nv_dout), .nv_req(nv_req), .nv_ack(nv_ack),
    .addr_err(addr_err), .nv_err(nv_err), .throttled(throttled), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  int          cyc, req_cycles, nerr, aerr, unstable, last_acc;
  logic        req_prev;
  logic [31:0] hold;
  logic [31:0] sb[$];
  logic [31:0] iss[$];
  int          iss_cyc[$];
  bit          gnt[$];

  // One clock: record grants before the edge, record issue events after it.
  task automatic tick();
    @(negedge clk);
    if (cpu_wen && cpu_ready) begin
      gnt.push_back(1'b0); last_acc = cyc + 1;
      if (cpu_addr >= 16'hE000) sb.push_back({cpu_addr, cpu_din});
    end
    if (dma_wen && dma_ready) begin
      gnt.push_back(1'b1); last_acc = cyc + 1;
      if (dma_addr >= 16'hE000) sb.push_back({dma_addr, dma_din});
    end
    @(posedge clk); #1;
    cyc++;
    if (nv_req && !req_prev) begin
      iss.push_back({nv_addr, nv_dout}); iss_cyc.push_back(cyc); hold = {nv_addr, nv_dout};
    end else if (nv_req && ({nv_addr, nv_dout} !== hold)) unstable++;
    if (nv_req)   req_cycles++;
    if (nv_err)   nerr++;
    if (addr_err) aerr++;
    req_prev = nv_req;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_wen = 1'b0; dma_wen = 1'b0; nv_ack = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0; req_prev = 1'b0; req_cycles = 0; nerr = 0; aerr = 0; unstable = 0; last_acc = 0;
    sb.delete(); iss.delete(); iss_cyc.delete(); gnt.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_wen = 1'b0; dma_wen = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    n_chk++; if ({cpu_ready, dma_ready, nv_req, addr_err, nv_err, throttled} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {cpu_ready, dma_ready, nv_req, addr_err, nv_err, throttled}); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_chk++; if ({nv_addr, nv_dout} !== 32'h0) begin n_fail++; $display("FAIL reset_nv_bus: got %h want 0", {nv_addr, nv_dout}); end
    n_chk++; if (dut.tokens_q !== 3'd4) begin n_fail++; $display("FAIL reset_tokens: got %0d want 4", dut.tokens_q); end
  endtask

  task automatic test_single();
    logic [31:0] got, exp;
    do_reset();
    cpu_addr = 16'hE010; cpu_din = 16'h1234; cpu_wen = 1'b1;
    tick(); cpu_wen = 1'b0;
    n_chk++; if (nv_req !== 1'b0 || fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL single_pushed: req=%b level=%0d want req=0 level=1", nv_req, fifo_level); end
    tick();
    n_chk++; if (iss.size() != 1 || sb.size() != 1) begin
      n_fail++; $display("FAIL single_issue: issued=%0d expected=%0d want 1/1", iss.size(), sb.size()); end
    else begin
      n_chk++; if (iss_cyc[0] != last_acc + 1) begin
        n_fail++; $display("FAIL single_latency: req at edge %0d want %0d", iss_cyc[0], last_acc + 1); end
      got = iss.pop_front(); exp = sb.pop_front();
      n_chk++; if (got !== exp || exp !== 32'hE010_1234) begin
        n_fail++; $display("FAIL single_data: got %h want %h", got, 32'hE010_1234); end
      void'(iss_cyc.pop_front());
    end
    n_chk++; if (dut.tokens_q !== 3'd3 || fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL single_tokens: tokens=%0d level=%0d want 3/1", dut.tokens_q, fifo_level); end
    tick(); tick();
    n_chk++; if (nv_req !== 1'b1 || {nv_addr, nv_dout} !== 32'hE010_1234) begin
      n_fail++; $display("FAIL single_hold: req=%b bus=%h want 1/e0101234", nv_req, {nv_addr, nv_dout}); end
    nv_ack = 1'b1; tick(); nv_ack = 1'b0;
    n_chk++; if (nv_req !== 1'b0 || fifo_level !== 3'd0 || nerr != 0) begin
      n_fail++; $display("FAIL single_ack: req=%b level=%0d nerr=%0d want 0/0/0", nv_req, fifo_level, nerr); end
  endtask

  task automatic test_contend();
    logic [31:0] got, exp;
    do_reset();
    cpu_wen = 1'b1; dma_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'hE100 + 16'(i); cpu_din = 16'hA000 + 16'(i);
      dma_addr = 16'hE200 + 16'(i); dma_din = 16'hB000 + 16'(i);
      tick();
    end
    n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL contend_level: got %0d want 4", fifo_level); end
    n_chk++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin
      n_fail++; $display("FAIL contend_full_ready: cpu=%b dma=%b want 0/0", cpu_ready, dma_ready); end
    n_chk++; if (gnt.size() != 4) begin n_fail++; $display("FAIL contend_grants: got %0d grants want 4", gnt.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_chk++; if (gnt[i] !== bit'(i % 2)) begin
        n_fail++; $display("FAIL contend_order[%0d]: got %0d want %0d", i, gnt[i], i % 2); end
    end
    cpu_wen = 1'b0; dma_wen = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    n_chk++; if (nerr != 4 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL contend_drain: nerr=%0d level=%0d want 4/0", nerr, fifo_level); end
    n_chk++; if (iss.size() != 4 || sb.size() != 4) begin
      n_fail++; $display("FAIL contend_issued: issued=%0d expected=%0d want 4/4", iss.size(), sb.size()); end
    else for (int i = 0; i < 4; i++) begin
      got = iss.pop_front(); exp = sb.pop_front();
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL contend_data[%0d]: got %h want %h", i, got, exp); end
    end
    n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL contend_stable: %0d bus changes in REQ want 0", unstable); end
  endtask

  task automatic test_timeout();
    logic [31:0] got;
    do_reset();
    cpu_addr = 16'hF00F; cpu_din = 16'h5A5A; cpu_wen = 1'b1;
    tick(); cpu_wen = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    n_chk++; if (req_cycles != 16) begin n_fail++; $display("FAIL timeout_len: req high %0d cycles want 16", req_cycles); end
    n_chk++; if (nerr != 1) begin n_fail++; $display("FAIL timeout_nv_err: %0d pulse cycles want 1", nerr); end
    n_chk++; if (nv_req !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL timeout_drop: req=%b level=%0d want 0/0", nv_req, fifo_level); end
    n_chk++; if (iss.size() != 1) begin n_fail++; $display("FAIL timeout_issue: issued %0d want 1", iss.size()); end
    else begin
      got = iss.pop_front();
      n_chk++; if (got !== 32'hF00F_5A5A) begin n_fail++; $display("FAIL timeout_data: got %h want f00f5a5a", got); end
    end
  endtask

  task automatic test_addr_filter();
    logic [31:0] got;
    do_reset();
    dma_addr = 16'hD000; dma_din = 16'h1111; dma_wen = 1'b1;
    tick(); dma_wen = 1'b0;
    n_chk++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_pulse: got %b want 1", addr_err); end
    tick();
    n_chk++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_clear: got %b want 0", addr_err); end
    cpu_addr = 16'hDFFF; cpu_din = 16'h2222; cpu_wen = 1'b1;
    tick(); cpu_wen = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_chk++; if (aerr != 2 || fifo_level !== 3'd0 || iss.size() != 0) begin
      n_fail++; $display("FAIL addr_reject: aerr=%0d level=%0d issued=%0d want 2/0/0", aerr, fifo_level, iss.size()); end
    cpu_addr = 16'hE000; cpu_din = 16'h3333; cpu_wen = 1'b1; nv_ack = 1'b1;
    tick(); cpu_wen = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    nv_ack = 1'b0;
    n_chk++; if (iss.size() != 1 || aerr != 2) begin
      n_fail++; $display("FAIL addr_boundary: issued=%0d aerr=%0d want 1/2", iss.size(), aerr); end
    else begin
      got = iss.pop_front();
      n_chk++; if (got !== 32'hE000_3333) begin n_fail++; $display("FAIL addr_boundary_data: got %h want e0003333", got); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    int exp_cyc[6] = '{2, 4, 6, 8, 201, 401};
    do_reset();
    nv_ack = 1'b1; cpu_wen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = 16'hE300 + 16'(i); cpu_din = 16'hC000 + 16'(i);
      tick();
    end
    cpu_wen = 1'b0;
    n_chk++; if (sb.size() != 6) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 6", sb.size()); end
    while (cyc < 150) tick();
    n_chk++; if (throttled !== 1'b1 || fifo_level !== 3'd2 || iss.size() != 4) begin
      n_fail++; $display("FAIL b2b_throttled: thr=%b level=%0d issued=%0d want 1/2/4", throttled, fifo_level, iss.size()); end
    while (cyc < 420) tick();
    nv_ack = 1'b0;
    n_chk++; if (iss.size() != 6) begin n_fail++; $display("FAIL b2b_issued: got %0d want 6", iss.size()); end
    else for (int i = 0; i < 6; i++) begin
      got = iss.pop_front(); exp = sb.pop_front();
      n_chk++; if (got !== exp || iss_cyc[i] != exp_cyc[i]) begin
        n_fail++; $display("FAIL b2b_issue[%0d]: got %h at %0d want %h at %0d", i, got, iss_cyc[i], exp, exp_cyc[i]); end
    end
    n_chk++; if (throttled !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL b2b_end: thr=%b level=%0d want 0/0", throttled, fifo_level); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 16'hE400 + 16'(i); cpu_din = 16'h7000 + 16'(i);
      tick();
    end
    cpu_wen = 1'b0;
    n_chk++; if (nv_req !== 1'b1 || fifo_level !== 3'd3) begin
      n_fail++; $display("FAIL rmid_setup: req=%b level=%0d want 1/3", nv_req, fifo_level); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (nv_req !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL rmid_async: req=%b level=%0d want 0/0", nv_req, fifo_level); end
    @(posedge clk); #1;
    reset = 1'b0; req_prev = 1'b0;
    tick();
    n_chk++; if (dut.tokens_q !== 3'd4 || fifo_level !== 3'd0 || nv_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: tokens=%0d level=%0d req=%b want 4/0/0", dut.tokens_q, fifo_level, nv_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_timeout();
    test_addr_filter();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
